// File: rtl/keccak_state_serializer_if.sv
// keccak_state_serializer_if: state-in / chunk-out handshake bundle.
// The serializer connects through the slave modport; its driver uses master.
interface keccak_state_serializer_if #(
  parameter int W = 64,
  parameter int CHUNK = 200
);
  localparam int NCHUNK = 25 * W / CHUNK;
  localparam int IXW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  logic pushin;
  logic [4:0][4:0][W-1:0] din;
  logic ready;
  logic stopin;
  logic pushout;
  logic [IXW-1:0] doutix;
  logic [CHUNK-1:0] dout;
  logic lastout;
  logic overrun;
  modport master (output pushin, din, stopin, input ready, pushout, doutix, dout, lastout, overrun);
  modport slave (input pushin, din, stopin, output ready, pushout, doutix, dout, lastout, overrun);
endinterface

// File: rtl/keccak_state_serializer.sv
// keccak_state_serializer: flattens a 5x5 lane state into FIPS-202 string order and emits CHUNK-bit pieces.
// Define SER_DBUF_EN to add a second state buffer so the next state can be accepted mid-stream.
module keccak_state_serializer #(
  parameter int W = 64,
  parameter int CHUNK = 200
) (
  input logic clk,
  input logic reset,
  keccak_state_serializer_if.slave bus
);
  localparam int SW = 25 * W;
  localparam int NCHUNK = SW / CHUNK;
  localparam int IXW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [IXW-1:0] LAST = IXW'(NCHUNK - 1);
  if (SW % CHUNK != 0) begin : g_bad_chunk
    $error("CHUNK must divide the state width 25*W");
  end
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [IXW-1:0] cnt, cnt_n;
  logic [SW-1:0] flat, act, act_n;
  logic xfer, done, accept;
`ifdef SER_DBUF_EN
  logic [SW-1:0] hold, hold_n;
  logic full, full_n;
`endif
  // lane (x,y) lands at string offset W*(5y+x)
  always_comb begin
    flat = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        flat[W*(5*y+x) +: W] = bus.din[x][y];
  end
  assign xfer = bus.pushout && !bus.stopin;
  assign done = xfer && cnt == LAST;
`ifdef SER_DBUF_EN
  assign bus.ready = !full || done;
`else
  assign bus.ready = state == IDLE || done;
`endif
  assign accept = bus.pushin && bus.ready;
  assign bus.pushout = state == SEND;
  assign bus.doutix = cnt;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    act_n = act;
`ifdef SER_DBUF_EN
    hold_n = hold;
    full_n = full;
`endif
    if (state == IDLE) begin
      if (accept) begin
        state_n = SEND;
        cnt_n = '0;
        act_n = flat;
      end
    end else if (done) begin
      cnt_n = '0;
`ifdef SER_DBUF_EN
      if (full) begin
        act_n = hold;
        full_n = accept;
        hold_n = accept ? flat : hold;
      end else if (accept) act_n = flat;
      else state_n = IDLE;
`else
      if (accept) act_n = flat;
      else state_n = IDLE;
`endif
    end else begin
      cnt_n = xfer ? cnt + IXW'(1) : cnt;
`ifdef SER_DBUF_EN
      if (accept) begin
        hold_n = flat;
        full_n = 1'b1;
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      act <= '0;
      bus.dout <= '0;
      bus.lastout <= 1'b0;
      bus.overrun <= 1'b0;
`ifdef SER_DBUF_EN
      hold <= '0;
      full <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      act <= act_n;
      bus.dout <= act_n[CHUNK*int'(cnt_n) +: CHUNK];
      bus.lastout <= state_n == SEND && cnt_n == LAST;
      bus.overrun <= bus.overrun || (bus.pushin && !bus.ready);
`ifdef SER_DBUF_EN
      hold <= hold_n;
      full <= full_n;
`endif
    end
endmodule

// File: tb/tb_keccak_state_serializer.sv
// tb_keccak_state_serializer: scoreboard bench for the chunked Keccak state serializer.
module tb_keccak_state_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keccak_state_serializer_if #(.W(64), .CHUNK(200)) b0();
  keccak_state_serializer_if #(.W(8), .CHUNK(40)) b1();
  keccak_state_serializer_if #(.W(16), .CHUNK(400)) b2();
  keccak_state_serializer #(.W(64), .CHUNK(200)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  keccak_state_serializer #(.W(8), .CHUNK(40)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  keccak_state_serializer #(.W(16), .CHUNK(400)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  typedef logic [4:0][4:0][63:0] st64_t;
  typedef struct { logic [2:0] ix; logic [199:0] data; logic last; } exp_t;
  typedef struct { int k; int stall_at; int stall_len; int at1; int r1; int at2; int r2; int exp_valid; int exp_ov; } vec_t;

  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;
  int nvalid;
  logic prev_stop = 1'b0;
  logic [199:0] prev_dout;
  logic [2:0] prev_ix;
  vec_t tv[6];

  task automatic chk(input string name, input logic [399:0] act, input logic [399:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [1599:0] flat64(input st64_t d);
    logic [1599:0] s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[64*(5*y+x) +: 64] = d[x][y];
    return s;
  endfunction

  function automatic st64_t pat(input int k);
    st64_t d;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        d[x][y] = 64'h0101_0101_0101_0101 * 64'(5*y + x + 1 + 25*k);
    return d;
  endfunction

  task automatic push64(input st64_t d);
    logic [1599:0] s;
    s = flat64(d);
    for (int k = 0; k < 8; k++) sbq.push_back('{3'(k), s[200*k +: 200], k == 7});
  endtask

  // compare this cycle's output, then advance one clock
  task automatic step();
    exp_t e;
    if (b0.pushout) nvalid++;
    if (prev_stop) begin
      chk("hold pushout", b0.pushout, 1);
      chk("hold doutix", b0.doutix, prev_ix);
      chk("hold dout", b0.dout, prev_dout);
    end
    prev_stop = b0.pushout && b0.stopin;
    prev_ix = b0.doutix;
    prev_dout = b0.dout;
    if (b0.pushout && !b0.stopin) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected chunk: got doutix %0d with empty scoreboard", b0.doutix);
      end else begin
        e = sbq.pop_front();
        chk("doutix", b0.doutix, e.ix);
        chk("dout", b0.dout, e.data);
        chk("lastout", b0.lastout, e.last);
      end
    end
    @(posedge clk);
    #1;
    b0.pushin = 1'b0;
  endtask

  task automatic inject(input st64_t d, input int r);
    b0.pushin = 1'b1;
    b0.din = d;
    chk("ready at inject", b0.ready, r);
    if (r != 0) push64(d);
  endtask

  task automatic drain(input vec_t v);
    int sc = 0;
    bit f1 = 0;
    bit f2 = 0;
    for (int i = 0; i < 40 && b0.pushout; i++) begin
      b0.stopin = int'(b0.doutix) == v.stall_at && sc < v.stall_len;
      if (b0.stopin) sc++;
      #1;
      if (!f1 && !b0.stopin && int'(b0.doutix) == v.at1) begin
        f1 = 1;
        inject(pat(v.k + 10), v.r1);
      end else if (!f2 && !b0.stopin && int'(b0.doutix) == v.at2) begin
        f2 = 1;
        inject(pat(v.k + 20), v.r2);
      end
      step();
    end
    b0.stopin = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [4:0][4:0][7:0] d8;
    logic [199:0] s8;
    logic [4:0][4:0][15:0] d16;
    logic [399:0] s16;
    tv[0] = '{0, -1, 0, -1, 0, -1, 0, 8, 0};
    tv[1] = '{1, 3, 3, -1, 0, -1, 0, 11, 0};
    tv[2] = '{2, 0, 2, -1, 0, -1, 0, 10, 0};
    tv[3] = '{3, -1, 0, 7, 1, -1, 0, 16, 0};
    tv[4] = '{4, 7, 1, 7, 1, -1, 0, 17, 0};
`ifdef SER_DBUF_EN
    tv[5] = '{5, -1, 0, 2, 1, 4, 0, 16, 1};
`else
    tv[5] = '{5, -1, 0, 2, 0, -1, 0, 8, 1};
`endif
    b0.pushin = 0; b0.stopin = 0; b0.din = '0;
    b1.pushin = 0; b1.stopin = 0; b1.din = '0;
    b2.pushin = 0; b2.stopin = 0; b2.din = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset pushout", b0.pushout, 0);
    chk("reset doutix", b0.doutix, 0);
    chk("reset dout", b0.dout, 0);
    chk("reset lastout", b0.lastout, 0);
    chk("reset overrun", b0.overrun, 0);
    chk("reset ready", b0.ready, 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 6; t++) begin
      nvalid = 0;
      b0.din = pat(tv[t].k);
      b0.pushin = 1'b1;
      chk("ready idle", b0.ready, 1);
      push64(pat(tv[t].k));
      step();
      chk("latency pushout", b0.pushout, 1);
      drain(tv[t]);
      chk("valid cycles", nvalid, tv[t].exp_valid);
      chk("pushout idle", b0.pushout, 0);
      chk("lastout idle", b0.lastout, 0);
      chk("scoreboard empty", sbq.size(), 0);
      chk("overrun", b0.overrun, tv[t].exp_ov);
    end

    // asynchronous reset in the middle of a state
    b0.din = pat(30);
    b0.pushin = 1'b1;
    push64(pat(30));
    step();
    for (int i = 0; i < 20 && !(b0.pushout && b0.doutix == 3'd5); i++) step();
    chk("reached doutix 5", b0.doutix, 5);
    reset = 1'b0;
    #1;
    chk("midreset pushout", b0.pushout, 0);
    chk("midreset doutix", b0.doutix, 0);
    chk("midreset dout", b0.dout, 0);
    chk("midreset lastout", b0.lastout, 0);
    chk("midreset overrun", b0.overrun, 0);
    chk("midreset ready", b0.ready, 1);
    sbq.delete();
    prev_stop = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    nvalid = 0;
    b0.din = pat(31);
    b0.pushin = 1'b1;
    push64(pat(31));
    step();
    chk("restart doutix", b0.doutix, 0);
    drain(tv[0]);
    chk("restart valid cycles", nvalid, 8);
    chk("restart scoreboard empty", sbq.size(), 0);

    // W=8, CHUNK=40: five chunks
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        d8[x][y] = 8'(7*(5*y + x) + 3);
        s8[8*(5*y+x) +: 8] = d8[x][y];
      end
    b1.din = d8;
    b1.pushin = 1'b1;
    @(posedge clk);
    #1;
    b1.pushin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("w8 pushout", b1.pushout, 1);
      chk("w8 doutix", b1.doutix, k);
      chk("w8 dout", b1.dout, s8[40*k +: 40]);
      chk("w8 lastout", b1.lastout, k == 4);
      @(posedge clk);
      #1;
    end
    chk("w8 pushout idle", b1.pushout, 0);

    // W=16, CHUNK=400: single chunk per state, one state per cycle
    for (int j = 0; j < 3; j++) begin
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++) begin
          d16[x][y] = 16'($urandom);
          s16[16*(5*y+x) +: 16] = d16[x][y];
        end
      b2.din = d16;
      b2.pushin = 1'b1;
      chk("w16 ready", b2.ready, 1);
      @(posedge clk);
      #1;
      chk("w16 pushout", b2.pushout, 1);
      chk("w16 doutix", b2.doutix, 0);
      chk("w16 lastout", b2.lastout, 1);
      chk("w16 dout", b2.dout, s16);
    end
    b2.pushin = 1'b0;
    @(posedge clk);
    #1;
    chk("w16 pushout idle", b2.pushout, 0);
    chk("w16 overrun", b2.overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
